if_fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the 5-stage MIPS core; the consumer of the hazard unit's Stall and IF_Flush.
- Owns the PC and drives a single-outstanding req/ack instruction-memory port.
- Applies stalls and redirects: branch, j/jal, jr/jalr.
- Presents the fetched instruction to ID together with a valid bit.

---
 rtl/core_pkg.sv | 30 +++
 rtl/if_fetch_stage_if.sv | 10 +
 rtl/if_fetch_stage_id_reg.sv | 53 +++++
 rtl/if_fetch_stage.sv | 134 +++++++++++++
 tb/tb_if_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end: state encoding, PCSrc codes,
// reset PC and the bubble instruction word.
package core_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  PCSRC_BRANCH     = 2'b00;
    localparam logic [1:0]  PCSRC_JUMP       = 2'b01;
    localparam logic [1:0]  PCSRC_JR         = 2'b10;  // any code with bit 1 set
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Bit 1 alone selects jr/jalr, so both 2'b10 and 2'b11 pick the register target.
    function automatic logic [31:0] sel_target(input logic [1:0]  pcsrc,
                                               input logic [31:0] branch_t,
                                               input logic [31:0] jump_t,
                                               input logic [31:0] jr_t);
        if (pcsrc[1])
            return jr_t;
        else if (pcsrc[0])
            return jump_t;
        else
            return branch_t;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Single-outstanding instruction memory port: req/addr from fetch, ack/rdata from memory.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc4_d, pc4_q;
    logic        valid_d, valid_q;

    // A bubble keeps pc4 so ID still sees the last real sequential PC.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else if (bubble) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, runs the single-outstanding fetch FSM and
// applies hazard-unit stalls and redirects before feeding the IF/ID register.
module if_fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Stall,
    input  logic                     IF_Flush,
    input  logic [1:0]               ID_PCSrc,
    input  logic [31:0]              ID_Branch_target,
    input  logic [31:0]              ID_Jump_target,
    input  logic [31:0]              ID_Jr_target,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              ID_Instruction,
    output logic [31:0]              ID_PC_plus4,
    output logic                     ID_Valid,
    output logic [31:0]              IF_PC
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  drain_addr_d, drain_addr_q;
    logic [31:0]  buf_d, buf_q;
    logic [31:0]  buf_pc4_d, buf_pc4_q;

    logic        adv, redirect, ack_v;
    logic [31:0] target, pc_plus4;
    logic        id_load, id_bubble;
    logic [31:0] id_instr_in, id_pc4_in;

    assign adv      = ~Stall;
    assign redirect = IF_Flush & ~Stall;
    assign target   = sel_target(ID_PCSrc, ID_Branch_target, ID_Jump_target, ID_Jr_target);
    assign pc_plus4 = pc_q + 32'd4;

    assign imem.req  = (state_q != HOLD);
    assign imem.addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    // An ack with no request outstanding is a protocol error and is dropped.
    assign ack_v     = imem.ack & imem.req;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        buf_pc4_d    = buf_pc4_q;
        id_load      = 1'b0;
        id_bubble    = 1'b0;
        id_instr_in  = imem.rdata;
        id_pc4_in    = pc_plus4;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    id_bubble = 1'b1;
                    pc_d      = target;
                    if (!ack_v) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (adv) begin
                    if (ack_v) begin
                        id_load = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        id_bubble = 1'b1;
                    end
                end else if (ack_v) begin
                    buf_d     = imem.rdata;
                    buf_pc4_d = pc_plus4;
                    pc_d      = pc_plus4;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    id_bubble = 1'b1;
                    pc_d      = target;
                    state_d   = FETCH;
                end else if (adv) begin
                    id_load     = 1'b1;
                    id_instr_in = buf_q;
                    id_pc4_in   = buf_pc4_q;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                // The stale response is thrown away; only the PC follows new redirects.
                if (redirect)
                    pc_d = target;
                if (adv)
                    id_bubble = 1'b1;
                if (ack_v)
                    state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        drain_addr_q <= drain_addr_d;
        buf_q        <= buf_d;
        buf_pc4_q    <= buf_pc4_d;
    end

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (id_load),
        .bubble   (id_bubble),
        .instr_in (id_instr_in),
        .pc4_in   (id_pc4_in),
        .instr    (ID_Instruction),
        .pc4      (ID_PC_plus4),
        .valid    (ID_Valid)
    );

    assign IF_PC = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stall/HOLD, drain on
// redirect, stall-masked flush, redirect from HOLD, reset mid-drain, PC wrap.
module tb_if_fetch_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, IF_Flush;
    logic [1:0]  ID_PCSrc;
    logic [31:0] ID_Branch_target, ID_Jump_target, ID_Jr_target;
    logic [31:0] ID_Instruction, ID_PC_plus4, IF_PC;
    logic        ID_Valid;

    int errors = 0;
    int checks = 0;

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Stall            (Stall),
        .IF_Flush         (IF_Flush),
        .ID_PCSrc         (ID_PCSrc),
        .ID_Branch_target (ID_Branch_target),
        .ID_Jump_target   (ID_Jump_target),
        .ID_Jr_target     (ID_Jr_target),
        .imem             (imem),
        .ID_Instruction   (ID_Instruction),
        .ID_PC_plus4      (ID_PC_plus4),
        .ID_Valid         (ID_Valid),
        .IF_PC            (IF_PC)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                          input logic vld);
        chk({tag, ".instr"}, ID_Instruction, ins);
        chk({tag, ".pc4"}, ID_PC_plus4, pc4);
        chk({tag, ".valid"}, {31'd0, ID_Valid}, {31'd0, vld});
    endtask

    task automatic chk_if(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] pc);
        chk({tag, ".req"}, {31'd0, imem.req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem.addr, addr);
        chk({tag, ".if_pc"}, IF_PC, pc);
    endtask

    task automatic drive(input logic stl, input logic fl, input logic ack, input logic [31:0] rd);
        Stall      = stl;
        IF_Flush   = fl;
        imem.ack   = ack;
        imem.rdata = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        ID_PCSrc = PCSRC_BRANCH;
        ID_Branch_target = 32'd0;
        ID_Jump_target   = 32'd0;
        ID_Jr_target     = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk_id("reset", 32'h0, 32'h0, 1'b0);
        chk_if("reset", 1'b1, 32'hBFC0_0000, 32'hBFC0_0000);

        // Sequential fetch with 1-cycle acks
        rst_n = 1'b1;
        tick();
        chk_id("seq.first_bubble", 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h1111_0000);
        tick();
        chk_id("seq.w0", 32'h1111_0000, 32'hBFC0_0004, 1'b1);
        chk_if("seq.w0", 1'b1, 32'hBFC0_0004, 32'hBFC0_0004);
        drive(1'b0, 1'b0, 1'b1, 32'h1111_0004);
        tick();
        chk_id("seq.w1", 32'h1111_0004, 32'hBFC0_0008, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h1111_0008);
        tick();
        chk_id("seq.w2", 32'h1111_0008, 32'hBFC0_000C, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h1111_000C);
        tick();
        chk_id("seq.w3", 32'h1111_000C, 32'hBFC0_0010, 1'b1);
        chk_if("seq.w3", 1'b1, 32'hBFC0_0010, 32'hBFC0_0010);

        // Stall as the ack for BFC00010 arrives -> HOLD
        drive(1'b1, 1'b0, 1'b1, 32'h2222_0010);
        tick();
        chk_id("hold.c1", 32'h1111_000C, 32'hBFC0_0010, 1'b1);
        chk_if("hold.c1", 1'b0, 32'h0, 32'hBFC0_0014);
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk_id("hold.c2", 32'h1111_000C, 32'hBFC0_0010, 1'b1);
        chk_if("hold.c2", 1'b0, 32'h0, 32'hBFC0_0014);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk_id("hold.c3", 32'h1111_000C, 32'hBFC0_0010, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_id("hold.release", 32'h2222_0010, 32'hBFC0_0014, 1'b1);
        chk_if("hold.release", 1'b1, 32'hBFC0_0014, 32'hBFC0_0014);
        drive(1'b0, 1'b0, 1'b1, 32'h3333_0014);
        tick();
        chk_id("resume.w5", 32'h3333_0014, 32'hBFC0_0018, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h3333_0018);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h3333_001C);
        tick();
        chk_id("resume.w7", 32'h3333_001C, 32'hBFC0_0020, 1'b1);
        chk_if("resume.w7", 1'b1, 32'hBFC0_0020, 32'hBFC0_0020);

        // Branch redirect while BFC00020 is pending -> DRAIN
        ID_PCSrc = 2'b00;
        ID_Branch_target = 32'hBFC0_0100;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk_id("drain.c1", NOP_INSTR, 32'hBFC0_0020, 1'b0);
        chk_if("drain.c1", 1'b1, 32'hBFC0_0020, 32'hBFC0_0100);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_if("drain.c2", 1'b1, 32'hBFC0_0020, 32'hBFC0_0100);
        tick();
        chk_id("drain.c3", NOP_INSTR, 32'hBFC0_0020, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'hBAD0_0020);
        tick();
        chk_id("drain.ack", NOP_INSTR, 32'hBFC0_0020, 1'b0);
        chk_if("drain.ack", 1'b1, 32'hBFC0_0100, 32'hBFC0_0100);
        drive(1'b0, 1'b0, 1'b1, 32'h4444_0100);
        tick();
        chk_id("drain.target", 32'h4444_0100, 32'hBFC0_0104, 1'b1);

        // Flush under stall is ignored until release
        ID_PCSrc = 2'b10;
        ID_Jr_target = 32'h8000_1000;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        chk_id("jr.stalled", 32'h4444_0100, 32'hBFC0_0104, 1'b1);
        chk_if("jr.stalled", 1'b1, 32'hBFC0_0104, 32'hBFC0_0104);
        drive(1'b0, 1'b1, 1'b1, 32'hBAD0_0104);
        tick();
        chk_id("jr.release", NOP_INSTR, 32'hBFC0_0104, 1'b0);
        chk_if("jr.release", 1'b1, 32'h8000_1000, 32'h8000_1000);
        drive(1'b0, 1'b0, 1'b1, 32'h5555_1000);
        tick();
        chk_id("jr.target", 32'h5555_1000, 32'h8000_1004, 1'b1);

        // Jump redirect out of HOLD discards the buffered word
        ID_PCSrc = 2'b01;
        ID_Jump_target = 32'hBFC0_0200;
        drive(1'b1, 1'b0, 1'b1, 32'h6666_1004);
        tick();
        chk_if("jhold.hold", 1'b0, 32'h0, 32'h8000_1008);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk_id("jhold.redirect", NOP_INSTR, 32'h8000_1004, 1'b0);
        chk_if("jhold.redirect", 1'b1, 32'hBFC0_0200, 32'hBFC0_0200);

        // Reset in the middle of a drain
        ID_PCSrc = 2'b00;
        ID_Branch_target = 32'hBFC0_0300;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk_if("rstdrain.drain", 1'b1, 32'hBFC0_0200, 32'hBFC0_0300);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_id("rstdrain.id", NOP_INSTR, 32'h0, 1'b0);
        chk_if("rstdrain.if", 1'b1, 32'hBFC0_0000, 32'hBFC0_0000);

        // jr with code 2'b11 to the top of memory, then PC+4 wraps to zero
        ID_PCSrc = 2'b11;
        ID_Jr_target = 32'hFFFF_FFFC;
        drive(1'b0, 1'b1, 1'b1, 32'hBAD0_0000);
        tick();
        chk_if("wrap.redirect", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b1, 32'h7777_FFFC);
        tick();
        chk_id("wrap.word", 32'h7777_FFFC, 32'h0000_0000, 1'b1);
        chk_if("wrap.pc", 1'b1, 32'h0000_0000, 32'h0000_0000);

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
